alu_op_sequencer: RTL and testbench

- Initiator-side controller for the 32-bit ripple ALU.
- Accepts operation requests over a valid/ready handshake and drives the ALU's A, B and 3-bit control inputs from registers.
- Waits a programmable number of cycles, then captures the ALU result and flags and returns them over a valid/ready response channel.
- Adds SLT and ABS, which the bare ALU lacks, by sequencing one or two ALU passes.

---
 rtl/alu_defs.sv | 52 +++++
 rtl/alu_op_map.sv | 43 ++++
 rtl/alu_op_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs.sv
// Shared definitions for the ALU op sequencer.
// Contents: ALU control codes, request opcodes, flag bit positions and
// the operand-select encodings used between alu_op_map and the top.
package alu_defs;

    // Control codes understood by the 32-bit ripple ALU
    localparam logic [2:0] ALU_ADD = 3'h2;
    localparam logic [2:0] ALU_SUB = 3'h3;
    localparam logic [2:0] ALU_AND = 3'h4;
    localparam logic [2:0] ALU_OR  = 3'h5;
    localparam logic [2:0] ALU_NOR = 3'h6;
    localparam logic [2:0] ALU_XOR = 3'h7;

    // Request opcodes seen on req_op
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_NOR = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_SLT = 3'd6;
    localparam logic [2:0] OP_ABS = 3'd7;

    // Bit positions inside rsp_flags = {overflow, zero, negative}
    localparam int FLAG_OVF  = 2;
    localparam int FLAG_ZERO = 1;
    localparam int FLAG_NEG  = 0;

    // What drives ALU input A
    localparam logic       ASEL_OPA  = 1'b0;
    localparam logic       ASEL_ZERO = 1'b1;

    // What drives ALU input B
    localparam logic [1:0] BSEL_OPB  = 2'd0;
    localparam logic [1:0] BSEL_ZERO = 2'd1;
    localparam logic [1:0] BSEL_OPA  = 2'd2;

    // Resolve a B-select code into the actual operand value
    function automatic logic [31:0] pick_b(input logic [1:0] sel,
                                           input logic [31:0] opa,
                                           input logic [31:0] opb);
        logic [31:0] value;
        value = opb;
        case (sel)
            BSEL_ZERO: value = 32'd0;
            BSEL_OPA:  value = opa;
            default:   value = opb;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/alu_op_map.sv
// Combinational mapping from (request op, pass, captured sign) to the
// ALU control code and the operand selects for that pass.
// Only ABS is two-pass: pass 0 probes the sign with A+0, pass 1 either
// negates (0-A) or passes A through (A+0).
module alu_op_map
    import alu_defs::*;
(
    input  logic [2:0] op,
    input  logic       pass,
    input  logic       neg_capture,
    output logic [2:0] control,
    output logic       a_sel,
    output logic [1:0] b_sel
);

    // Decode the op into control code and operand routing for this pass
    always_comb begin
        control = ALU_ADD;
        a_sel   = ASEL_OPA;
        b_sel   = BSEL_OPB;
        case (op)
            OP_ADD: control = ALU_ADD;
            OP_SUB: control = ALU_SUB;
            OP_AND: control = ALU_AND;
            OP_OR:  control = ALU_OR;
            OP_NOR: control = ALU_NOR;
            OP_XOR: control = ALU_XOR;
            OP_SLT: control = ALU_SUB;
            OP_ABS: begin
                if (pass && neg_capture) begin
                    control = ALU_SUB;
                    a_sel   = ASEL_ZERO;
                    b_sel   = BSEL_OPA;
                end else begin
                    control = ALU_ADD;
                    b_sel   = BSEL_ZERO;
                end
            end
            default: control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator-side controller for the 32-bit ripple ALU.
// Accepts a request, drives the ALU from registers, waits ALU_LATENCY
// cycles per pass, then returns result and flags on a valid/ready channel.
// SLT is derived from a subtraction; ABS takes two ALU passes.
// Optional build macro ALU_STICKY_OVF_EN adds sticky_ovf / ovf_clear.
module alu_op_sequencer
    import alu_defs::*;
#(
    parameter int ALU_LATENCY = 1
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [2:0]  rsp_flags,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [2:0]  alu_control,
    input  logic [31:0] alu_out,
    input  logic        alu_overflow,
    input  logic        alu_zero,
    input  logic        alu_negative
`ifdef ALU_STICKY_OVF_EN
    ,
    input  logic        ovf_clear,
    output logic        sticky_ovf
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [1:0] LAST_COUNT = 2'(ALU_LATENCY - 1);

    logic [1:0]  state;
    logic        pass_q;
    logic [1:0]  count_q;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;

    logic [2:0]  map_op;
    logic        map_pass;
    logic [31:0] map_a;
    logic [31:0] map_b;
    logic [2:0]  map_control;
    logic        map_a_sel;
    logic [1:0]  map_b_sel;
    logic [31:0] drive_a;
    logic [31:0] drive_b;

    logic        last_count;
    logic        abs_first;
    logic        capture_done;
    logic [2:0]  cap_flags;
    logic [31:0] cap_data;

    assign req_ready = (state == IDLE);

    alu_op_map u_map (
        .op          (map_op),
        .pass        (map_pass),
        .neg_capture (alu_negative),
        .control     (map_control),
        .a_sel       (map_a_sel),
        .b_sel       (map_b_sel)
    );

    // In IDLE the map sees the incoming request for pass 0; otherwise it
    // sees the latched request and prepares pass 1 from the live sign bit
    always_comb begin
        map_op   = op_q;
        map_pass = 1'b1;
        map_a    = a_q;
        map_b    = b_q;
        if (state == IDLE) begin
            map_op   = req_op;
            map_pass = 1'b0;
            map_a    = req_a;
            map_b    = req_b;
        end
        drive_a = (map_a_sel == ASEL_ZERO) ? 32'd0 : map_a;
        drive_b = pick_b(map_b_sel, map_a, map_b);
    end

    // Pass bookkeeping and the value captured when the final pass completes
    always_comb begin
        last_count   = (count_q == LAST_COUNT);
        abs_first    = (op_q == OP_ABS) && !pass_q;
        capture_done = (state == EXEC) && last_count && !abs_first;
        cap_flags            = 3'b000;
        cap_flags[FLAG_OVF]  = alu_overflow;
        cap_flags[FLAG_ZERO] = alu_zero;
        cap_flags[FLAG_NEG]  = alu_negative;
        cap_data = alu_out;
        if (op_q == OP_SLT) begin
            cap_data = {31'b0, alu_negative ^ alu_overflow};
        end
    end

    // Main FSM: accept, run one or two timed ALU passes, hold the response
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pass_q      <= 1'b0;
            count_q     <= 2'd0;
            op_q        <= OP_ADD;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            rsp_valid   <= 1'b0;
            rsp_data    <= 32'd0;
            rsp_flags   <= 3'b000;
            alu_A       <= 32'd0;
            alu_B       <= 32'd0;
            alu_control <= ALU_ADD;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q        <= req_op;
                        a_q         <= req_a;
                        b_q         <= req_b;
                        alu_A       <= drive_a;
                        alu_B       <= drive_b;
                        alu_control <= map_control;
                        pass_q      <= 1'b0;
                        count_q     <= 2'd0;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (!last_count) begin
                        count_q <= count_q + 2'd1;
                    end else if (abs_first) begin
                        alu_A       <= drive_a;
                        alu_B       <= drive_b;
                        alu_control <= map_control;
                        pass_q      <= 1'b1;
                        count_q     <= 2'd0;
                    end else begin
                        rsp_data  <= cap_data;
                        rsp_flags <= cap_flags;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_STICKY_OVF_EN
    // Sticky overflow: set by any captured overflowing response, set beats clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sticky_ovf <= 1'b0;
        end else if (capture_done && cap_flags[FLAG_OVF]) begin
            sticky_ovf <= 1'b1;
        end else if (ovf_clear) begin
            sticky_ovf <= 1'b0;
        end
    end
`else
    logic unused_capture;
    assign unused_capture = capture_done;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: two instances (ALU_LATENCY 1 and 3)
// share the request/response stimulus, each driven by a behavioural ALU.
module tb_alu_op_sequencer;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  exp_ctl;
        logic [31:0] exp_data;
        logic [2:0]  exp_flags;
    } vec_t;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_ready;

    logic        req_ready_1, rsp_valid_1;
    logic [31:0] rsp_data_1, alu_a_1, alu_b_1, alu_out_1;
    logic [2:0]  rsp_flags_1, alu_control_1;
    logic        alu_overflow_1, alu_zero_1, alu_negative_1;

    logic        req_ready_3, rsp_valid_3;
    logic [31:0] rsp_data_3, alu_a_3, alu_b_3, alu_out_3;
    logic [2:0]  rsp_flags_3, alu_control_3;
    logic        alu_overflow_3, alu_zero_3, alu_negative_3;

    int checks;
    int failures;
    vec_t vecs [13];

    alu_op_sequencer #(.ALU_LATENCY(1)) u_dut1 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready_1), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data_1), .rsp_flags(rsp_flags_1),
        .alu_A(alu_a_1), .alu_B(alu_b_1), .alu_control(alu_control_1),
        .alu_out(alu_out_1), .alu_overflow(alu_overflow_1),
        .alu_zero(alu_zero_1), .alu_negative(alu_negative_1)
    );

    alu_op_sequencer #(.ALU_LATENCY(3)) u_dut3 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready_3), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data_3), .rsp_flags(rsp_flags_3),
        .alu_A(alu_a_3), .alu_B(alu_b_3), .alu_control(alu_control_3),
        .alu_out(alu_out_3), .alu_overflow(alu_overflow_3),
        .alu_zero(alu_zero_3), .alu_negative(alu_negative_3)
    );

    // Behavioural 32-bit ALU: returns {overflow, zero, negative, result}
    function automatic logic [34:0] alu_model(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [2:0] ctl);
        logic [31:0] r;
        logic        ovf;
        ovf = 1'b0;
        case (ctl)
            3'h2: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
            3'h3: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
            3'h4: r = a & b;
            3'h5: r = a | b;
            3'h6: r = ~(a | b);
            3'h7: r = a ^ b;
            default: r = 32'd0;
        endcase
        return {ovf, (r == 32'd0), r[31], r};
    endfunction

    // ALU models feeding each instance
    always_comb begin
        {alu_overflow_1, alu_zero_1, alu_negative_1, alu_out_1} = alu_model(alu_a_1, alu_b_1, alu_control_1);
        {alu_overflow_3, alu_zero_3, alu_negative_3, alu_out_3} = alu_model(alu_a_3, alu_b_3, alu_control_3);
    end

    // Free-running clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One comparison, counted, reporting on mismatch
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Issue one request to both instances and check the full transaction
    task automatic applyStimulus(input vec_t v);
        int lat1;
        int lat3;
        int exp1;
        int exp3;
        exp1 = (v.op == 3'd7) ? 2 : 1;
        exp3 = (v.op == 3'd7) ? 6 : 3;
        req_op = v.op;
        req_a = v.a;
        req_b = v.b;
        req_valid = 1'b1;
        checkOutput("req_ready_idle_1", {31'b0, req_ready_1}, 32'd1);
        checkOutput("req_ready_idle_3", {31'b0, req_ready_3}, 32'd1);
        @(posedge clock); #1;
        req_valid = 1'b0;
        checkOutput("alu_control_pass0_1", {29'b0, alu_control_1}, {29'b0, v.exp_ctl});
        checkOutput("alu_control_pass0_3", {29'b0, alu_control_3}, {29'b0, v.exp_ctl});
        lat1 = -1;
        lat3 = -1;
        for (int c = 1; c <= 20; c++) begin
            if (lat1 >= 0 && lat3 >= 0) break;
            @(posedge clock); #1;
            if (rsp_valid_1 && lat1 < 0) lat1 = c;
            if (rsp_valid_3 && lat3 < 0) lat3 = c;
        end
        checkOutput("latency_1", lat1, exp1);
        checkOutput("latency_3", lat3, exp3);
        checkOutput("rsp_data_1", rsp_data_1, v.exp_data);
        checkOutput("rsp_data_3", rsp_data_3, v.exp_data);
        checkOutput("rsp_flags_1", {29'b0, rsp_flags_1}, {29'b0, v.exp_flags});
        checkOutput("rsp_flags_3", {29'b0, rsp_flags_3}, {29'b0, v.exp_flags});
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        checkOutput("rsp_valid_drop_1", {31'b0, rsp_valid_1}, 32'd0);
        checkOutput("rsp_valid_drop_3", {31'b0, rsp_valid_3}, 32'd0);
    endtask

    initial begin
        int seen;
        checks = 0;
        failures = 0;
        reset = 1'b0;
        req_valid = 1'b0;
        req_op = 3'd0;
        req_a = 32'd0;
        req_b = 32'd0;
        rsp_ready = 1'b0;

        //           op     a             b             ctl   data          flags
        vecs[0]  = '{3'd0, 32'h7FFFFFFF, 32'h00000001, 3'h2, 32'h80000000, 3'b101};
        vecs[1]  = '{3'd1, 32'h00000005, 32'h00000005, 3'h3, 32'h00000000, 3'b010};
        vecs[2]  = '{3'd6, 32'h80000000, 32'h00000001, 3'h3, 32'h00000001, 3'b100};
        vecs[3]  = '{3'd6, 32'h00000003, 32'hFFFFFFFE, 3'h3, 32'h00000000, 3'b000};
        vecs[4]  = '{3'd7, 32'hFFFFFFFB, 32'h12345678, 3'h2, 32'h00000005, 3'b000};
        vecs[5]  = '{3'd7, 32'h80000000, 32'h00000000, 3'h2, 32'h80000000, 3'b101};
        vecs[6]  = '{3'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 3'h4, 32'h00F000F0, 3'b000};
        vecs[7]  = '{3'd3, 32'h00000000, 32'h00000000, 3'h5, 32'h00000000, 3'b010};
        vecs[8]  = '{3'd4, 32'h00000000, 32'h00000000, 3'h6, 32'hFFFFFFFF, 3'b001};
        vecs[9]  = '{3'd5, 32'hA5A5A5A5, 32'hFFFFFFFF, 3'h7, 32'h5A5A5A5A, 3'b000};
        vecs[10] = '{3'd7, 32'h00000007, 32'hFFFFFFFF, 3'h2, 32'h00000007, 3'b000};
        vecs[11] = '{3'd6, 32'hFFFFFFFF, 32'h00000000, 3'h3, 32'h00000001, 3'b001};
        vecs[12] = '{3'd1, 32'h00000000, 32'h00000001, 3'h3, 32'hFFFFFFFF, 3'b001};

        // Reset state, with a request held during reset that must be ignored
        req_valid = 1'b1;
        req_op = 3'd0;
        req_a = 32'h11111111;
        req_b = 32'h22222222;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_rsp_valid", {31'b0, rsp_valid_1}, 32'd0);
        checkOutput("reset_rsp_data", rsp_data_1, 32'd0);
        checkOutput("reset_rsp_flags", {29'b0, rsp_flags_3}, 32'd0);
        checkOutput("reset_alu_a", alu_a_3, 32'd0);
        checkOutput("reset_alu_b", alu_b_1, 32'd0);
        checkOutput("reset_alu_control", {29'b0, alu_control_1}, 32'h2);
        checkOutput("reset_req_ready", {31'b0, req_ready_3}, 32'd1);
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;

        // Table-driven transactions
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
        end

        // ABS of a negative: pass 1 must drive 0 - A on the slow instance
        req_op = 3'd7;
        req_a = 32'hFFFFFFFB;
        req_b = 32'h0;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("abs_pass1_control", {29'b0, alu_control_3}, 32'h3);
        checkOutput("abs_pass1_a", alu_a_3, 32'd0);
        checkOutput("abs_pass1_b", alu_b_3, 32'hFFFFFFFB);
        seen = 0;
        for (int c = 0; c < 20 && !rsp_valid_3; c++) begin
            @(posedge clock); #1;
        end
        checkOutput("abs_seq_data", rsp_data_3, 32'd5);
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;

        // Backpressure: response held stable, no new request accepted
        req_op = 3'd0;
        req_a = 32'd10;
        req_b = 32'd20;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_b = 32'd99;
        for (int c = 0; c < 20 && !(rsp_valid_1 && rsp_valid_3); c++) begin
            @(posedge clock); #1;
        end
        checkOutput("bp_valid_3", {31'b0, rsp_valid_3}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clock); #1;
            checkOutput("bp_data_1", rsp_data_1, 32'd30);
            checkOutput("bp_data_3", rsp_data_3, 32'd30);
            checkOutput("bp_req_ready_1", {31'b0, req_ready_1}, 32'd0);
            checkOutput("bp_rsp_valid_3", {31'b0, rsp_valid_3}, 32'd1);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        checkOutput("bp_release_ready_1", {31'b0, req_ready_1}, 32'd1);
        checkOutput("bp_release_ready_3", {31'b0, req_ready_3}, 32'd1);
        checkOutput("bp_release_valid_1", {31'b0, rsp_valid_1}, 32'd0);

        // Reset pulsed mid-EXEC aborts without a response
        req_op = 3'd7;
        req_a = 32'hFFFFFFF0;
        req_b = 32'h0;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        checkOutput("midreset_rsp_valid_1", {31'b0, rsp_valid_1}, 32'd0);
        checkOutput("midreset_alu_control_1", {29'b0, alu_control_1}, 32'h2);
        checkOutput("midreset_alu_control_3", {29'b0, alu_control_3}, 32'h2);
        checkOutput("midreset_req_ready_3", {31'b0, req_ready_3}, 32'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock); #1;
            if (rsp_valid_1 || rsp_valid_3) seen++;
        end
        checkOutput("midreset_no_response", seen, 32'd0);
        applyStimulus(vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
